// File: rtl/dma_stream_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : dma_stream_ctrl_if
// Description : Control, source-memory read and destination-stream signals
//               of the strided DMA stream controller.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
interface dma_stream_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 16
);
   // transfer request
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] src_stride;
   logic [ADDR_W-1:0] dst_addr;
   logic [LEN_W-1:0]  length;
   logic              busy;
   logic              done;
   // source memory read port
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   // destination stream
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;

   // DMA engine side
   modport master (
      input  start, abort, src_addr, src_stride, dst_addr, length,
      input  mem_rd_data, out_ready,
      output busy, done, mem_rd_en, mem_rd_addr,
      output out_valid, out_data, out_addr
   );

   // requester / memory / consumer side
   modport slave (
      output start, abort, src_addr, src_stride, dst_addr, length,
      output mem_rd_data, out_ready,
      input  busy, done, mem_rd_en, mem_rd_addr,
      input  out_valid, out_data, out_addr
   );
endinterface
`default_nettype wire

// File: rtl/dma_stream_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : dma_stream_ctrl
// Description : Strided-read to addressed-stream DMA engine. Issues source
//               reads with 1-cycle latency and forwards words to a
//               valid/ready stream through a 2-entry skid FIFO.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module dma_stream_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 16
) (
   input  wire logic        clk,
   input  wire logic        rst,
   dma_stream_ctrl_if.master bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issued;
   logic [LEN_W-1:0]  accepted;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] stride_q;
   logic [ADDR_W-1:0] dst_q;
   logic [DATA_W-1:0] fifo_mem [0:1];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_count;
   logic              inflight;

   logic              rd_en;
   logic              start_ok;
   logic              flush;
   logic              stored_nz;
   logic              out_valid;
   logic              pop;
   logic              pop_stored;
   logic              push;
   logic              last_read;
   logic              last_accept;

   // The returning read word is visible on the stream in the cycle it arrives
   // (bypass), so stored words plus the in-flight word form one logical queue.
   assign start_ok    = (state == ST_IDLE) && bus.start && !bus.abort;
   assign flush       = bus.abort && (state != ST_IDLE);
   assign stored_nz   = (fifo_count != 2'd0);
   assign out_valid   = stored_nz || inflight;
   assign pop         = out_valid && bus.out_ready;
   assign pop_stored  = pop && stored_nz;
   assign push        = inflight && (stored_nz || !bus.out_ready);
   assign last_read   = (issued + LEN_W'(1)) == len_q;
   assign last_accept = (accepted + LEN_W'(1)) == len_q;

   assign bus.out_valid   = out_valid;
   assign bus.out_data    = stored_nz ? fifo_mem[rd_ptr]
                          : (inflight ? bus.mem_rd_data : '0);
   assign bus.out_addr    = dst_q;
   assign bus.mem_rd_addr = rd_addr;
   assign bus.mem_rd_en   = rd_en;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // FSM next state; abort returns to IDLE from any active state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start_ok) state_nxt = (bus.length == '0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (bus.abort) state_nxt = ST_IDLE;
                   else if (rd_en && last_read) state_nxt = ST_DRAIN;
         ST_DRAIN: if (bus.abort) state_nxt = ST_IDLE;
                   else if (pop && last_accept) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs; a read is issued only while the logical queue has room
   always_comb begin
      bus.busy = (state == ST_RUN) || (state == ST_DRAIN);
      bus.done = (state == ST_DONE);
      rd_en    = (state == ST_RUN) && (issued < len_q)
              && (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);
   end

   // Transfer parameters and read/accept counters, latched on an accepted start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q    <= '0;
         issued   <= '0;
         accepted <= '0;
         rd_addr  <= '0;
         stride_q <= '0;
         dst_q    <= '0;
      end else if (start_ok) begin
         len_q    <= bus.length;
         issued   <= '0;
         accepted <= '0;
         rd_addr  <= bus.src_addr;
         stride_q <= bus.src_stride;
         dst_q    <= bus.dst_addr;
      end else begin
         if (rd_en) begin
            rd_addr <= rd_addr + stride_q;
            issued  <= issued + LEN_W'(1);
         end
         if (pop) begin
            dst_q    <= dst_q + ADDR_W'(1);
            accepted <= accepted + LEN_W'(1);
         end
      end
   end

   // In-flight flag; a read issued in an abort cycle returns data nobody keeps
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) inflight <= 1'b0;
      else      inflight <= rd_en && !bus.abort;
   end

   // Skid FIFO: holds returned words the consumer has not yet taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_count  <= 2'd0;
      end else if (flush) begin
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_count  <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= bus.mem_rd_data;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop_stored) rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + 2'(push) - 2'(pop_stored);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dma_stream_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_dma_stream_ctrl
// Description : Randomised self-checking bench for dma_stream_ctrl against a
//               cycle-level transfer model (issued/accepted word counts).
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_dma_stream_ctrl;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int LEN_W  = 16;

   logic clk = 1'b0;
   logic rst;
   int   tests  = 0;
   int   failed = 0;
   logic [15:0] salt = 16'h1234;

   always #5 clk = ~clk;

   dma_stream_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   dma_stream_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      logic [15:0] m;
      m = a * 16'h9E37;
      return m ^ salt;
   endfunction

   // source memory: data valid exactly one cycle after the strobe, junk otherwise
   always @(posedge clk)
      bus.mem_rd_data <= bus.mem_rd_en ? mem_fn(bus.mem_rd_addr) : 16'($urandom);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".busy"},  32'(bus.busy), 32'd0);
      check({tag, ".done"},  32'(bus.done), 32'd0);
      check({tag, ".rd_en"}, 32'(bus.mem_rd_en), 32'd0);
      check({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      check_idle(tag);
      check({tag, ".rd_addr"},  32'(bus.mem_rd_addr), 32'd0);
      check({tag, ".out_data"}, 32'(bus.out_data), 32'd0);
      check({tag, ".out_addr"}, 32'(bus.out_addr), 32'd0);
   endtask

   task automatic scramble_inputs();
      bus.start      = 1'($urandom_range(0, 1));
      bus.src_addr   = 16'($urandom);
      bus.src_stride = 16'($urandom);
      bus.dst_addr   = 16'($urandom);
      bus.length     = 16'($urandom);
   endtask

   // mode: 0 ready high, 1 ready toggling, 2 ready random, 3 ready low
   task automatic run_xfer(input logic [15:0] src, input logic [15:0] stride,
                           input logic [15:0] dst, input int len, input int mode,
                           input int abort_cyc, input int rst_cyc);
      int issued;
      int accepted;
      int occ;
      logic exp_rd, exp_val, exp_done;
      salt           = 16'($urandom);
      bus.src_addr   = src;
      bus.src_stride = stride;
      bus.dst_addr   = dst;
      bus.length     = 16'(len);
      bus.start      = 1'b1;
      bus.abort      = 1'b0;
      bus.out_ready  = 1'b0;
      issued   = 0;
      accepted = 0;
      @(posedge clk); #1;
      for (int c = 1; c <= 6 * len + 40; c++) begin
         scramble_inputs();
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = c[0];
            2:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
         endcase
         bus.abort = (c == abort_cyc);
         if (c == rst_cyc) begin
            bus.start = 1'b0;
            bus.abort = 1'b0;
            #1 rst = 1'b0;
            #1 check_zero("rst_async");
            #3 rst = 1'b1;
            @(posedge clk); #2;
            check_zero("rst_release");
            return;
         end
         #1;
         occ      = issued - accepted;
         exp_rd   = (issued < len) && (occ < 2);
         exp_val  = (occ > 0);
         exp_done = (accepted == len);
         check("rd_en", 32'(bus.mem_rd_en), 32'(exp_rd));
         check("out_valid", 32'(bus.out_valid), 32'(exp_val));
         check("busy", 32'(bus.busy), 32'(!exp_done));
         check("done", 32'(bus.done), 32'(exp_done));
         if (exp_rd)
            check("rd_addr", 32'(bus.mem_rd_addr), 32'(16'(src + stride * 16'(issued))));
         if (exp_val) begin
            check("out_data", 32'(bus.out_data), 32'(mem_fn(16'(src + stride * 16'(accepted)))));
            check("out_addr", 32'(bus.out_addr), 32'(16'(dst + 16'(accepted))));
         end
         if (exp_rd) issued++;
         if (exp_val && bus.out_ready) accepted++;
         if (c == abort_cyc) begin
            @(posedge clk); #1;
            bus.abort = 1'b0;
            bus.start = 1'b0;
            #1 check_idle("abort_idle");
            return;
         end
         if (exp_done) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            #1 check_idle("post_done");
            return;
         end
         @(posedge clk); #1;
      end
      check("timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b0;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.src_addr   = '0;
      bus.src_stride = '0;
      bus.dst_addr   = '0;
      bus.length     = '0;
      bus.out_ready  = 1'b0;
      #12 check_zero("reset");
      rst = 1'b1;
      @(posedge clk); #1;
      check_idle("idle0");
      // abort while idle changes nothing
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      #1 check_idle("idle_abort");

      run_xfer(16'h0010, 16'd1, 16'h0200, 4, 0, 0, 0);
      run_xfer(16'h0000, 16'd3, 16'h0040, 6, 1, 0, 0);
      run_xfer(16'hFFFE, 16'd1, 16'hFFFF, 3, 0, 0, 0);
      run_xfer(16'h1234, 16'd5, 16'h0800, 0, 0, 0, 0);
      run_xfer(16'h0100, 16'd2, 16'h0300, 8, 3, 4, 0);
      run_xfer(16'h0500, 16'd1, 16'h0600, 2, 0, 0, 0);
      run_xfer(16'h0700, 16'd4, 16'h0900, 8, 0, 0, 3);
      run_xfer(16'h0A00, 16'd1, 16'h0B00, 1, 0, 0, 0);

      for (int t = 0; t < 30; t++) begin
         int len;
         int ab;
         len = $urandom_range(0, 12);
         ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len + 3) : 0;
         run_xfer(16'($urandom), 16'($urandom), 16'($urandom), len,
                  $urandom_range(0, 2), ab, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
`default_nettype wire
